// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt request front end.
package irq_pkg;

    localparam int NIRQ = 7;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} statetype;

    // Vector 0 ("none") maps to an all-zero mask, so it can never clear a line.
    function automatic logic [NIRQ:1] vec_to_onehot(input logic [2:0] vec);
        logic [NIRQ:1] oh;
        for (int i = 1; i <= NIRQ; i++) begin
            oh[i] = (vec == 3'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/irq_edge.sv
// Request qualifier: produces the per-line set vector for the pending register,
// either from rising edges of irq or from the raw level.
module irq_edge
    import irq_pkg::*;
#(
    parameter bit EDGE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ:1]   irq,
    output logic [NIRQ:1]   set
);

    logic [NIRQ:1] irq_q;
    logic [NIRQ:1] irq_d;

    always_comb begin
        irq_d = irq;
    end

    // Clearing irq_q in reset makes a line already high at reset release look like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_d;
        end
    end

    always_comb begin
        set = EDGE ? (irq & ~irq_q) : irq;
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt request front end: pending/mask register, priority pick and a
// valid/ack then eoi handshake with the CPU. Line 7 is highest priority.
module irq_controller
    import irq_pkg::*;
#(
    parameter bit EDGE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ:1]   irq,
    input  logic [NIRQ:1]   mask,
    input  logic            ack,
    input  logic            eoi,
    output logic            int_valid,
    output logic [2:0]      int_vec,
    output logic            in_service,
    output logic [NIRQ:1]   pending
);

    statetype       state_q, state_d;
    logic [2:0]     int_vec_q, int_vec_d;
    logic           int_valid_q, int_valid_d;
    logic           in_service_q, in_service_d;
    logic [NIRQ:1]  pending_q, pending_d;

    logic [NIRQ:1]  set;
    logic [NIRQ:1]  clr;
    logic [NIRQ:1]  candidates;
    logic [2:0]     cand_vec;
    logic           ack_accept;

    irq_edge #(
        .EDGE (EDGE)
    ) u_irq_edge (
        .clk   (clk),
        .reset (reset),
        .irq   (irq),
        .set   (set)
    );

    always_comb begin
        candidates = pending_q & ~mask;
        cand_vec   = 3'd0;
        if (candidates[7]) begin
            cand_vec = 3'd7;
        end else if (candidates[6]) begin
            cand_vec = 3'd6;
        end else if (candidates[5]) begin
            cand_vec = 3'd5;
        end else if (candidates[4]) begin
            cand_vec = 3'd4;
        end else if (candidates[3]) begin
            cand_vec = 3'd3;
        end else if (candidates[2]) begin
            cand_vec = 3'd2;
        end else if (candidates[1]) begin
            cand_vec = 3'd1;
        end else begin
            cand_vec = 3'd0;
        end
    end

    // A fresh request on the line being acknowledged survives the clear.
    always_comb begin
        ack_accept = (state_q == REQ) && ack;
        clr        = ack_accept ? vec_to_onehot(int_vec_q) : '0;
        pending_d  = (pending_q & ~clr) | set;
    end

    always_comb begin
        state_d      = state_q;
        int_vec_d    = int_vec_q;
        int_valid_d  = int_valid_q;
        in_service_d = in_service_q;
        case (state_q)
            IDLE: begin
                if (cand_vec != 3'd0) begin
                    state_d     = REQ;
                    int_vec_d   = cand_vec;
                    int_valid_d = 1'b1;
                end
            end
            REQ: begin
                if (ack) begin
                    state_d      = SERVICE;
                    int_valid_d  = 1'b0;
                    in_service_d = 1'b1;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_d      = IDLE;
                    int_vec_d    = 3'd0;
                    in_service_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                int_vec_d    = 3'd0;
                int_valid_d  = 1'b0;
                in_service_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            int_vec_q    <= 3'd0;
            int_valid_q  <= 1'b0;
            in_service_q <= 1'b0;
            pending_q    <= '0;
        end else begin
            state_q      <= state_d;
            int_vec_q    <= int_vec_d;
            int_valid_q  <= int_valid_d;
            in_service_q <= in_service_d;
            pending_q    <= pending_d;
        end
    end

    assign int_valid  = int_valid_q;
    assign int_vec    = int_vec_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: a per-cycle vector table for the edge-mode
// instance plus hand-written sequences for reset release and level mode.
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:1] irq;
    logic [7:1] mask;
    logic       ack;
    logic       eoi;

    logic       e_valid, l_valid;
    logic [2:0] e_vec, l_vec;
    logic       e_insvc, l_insvc;
    logic [7:1] e_pend, l_pend;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic [7:1] irq;
        logic [7:1] mask;
        logic       ack;
        logic       eoi;
        logic       ev;
        logic [2:0] evec;
        logic       eis;
        logic [7:1] epend;
    } vec_t;

    vec_t vecs[$];

    irq_controller #(.EDGE(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask       (mask),
        .ack        (ack),
        .eoi        (eoi),
        .int_valid  (e_valid),
        .int_vec    (e_vec),
        .in_service (e_insvc),
        .pending    (e_pend)
    );

    irq_controller #(.EDGE(1'b0)) dut_lvl (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask       (mask),
        .ack        (ack),
        .eoi        (eoi),
        .int_valid  (l_valid),
        .int_vec    (l_vec),
        .in_service (l_insvc),
        .pending    (l_pend)
    );

    always #5 clk = ~clk;

    task automatic addVec(input logic r, input logic [7:1] i, input logic [7:1] m,
                          input logic a, input logic e, input logic ev,
                          input logic [2:0] evec, input logic eis, input logic [7:1] ep);
        vec_t v;
        v.rst = r; v.irq = i; v.mask = m; v.ack = a; v.eoi = e;
        v.ev = ev; v.evec = evec; v.eis = eis; v.epend = ep;
        vecs.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic applyStimulus(input logic r, input logic [7:1] i, input logic [7:1] m,
                                 input logic a, input logic e);
        @(negedge clk);
        reset = r; irq = i; mask = m; ack = a; eoi = e;
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic av, input logic [2:0] avec,
                               input logic ais, input logic [7:1] apend, input logic ev,
                               input logic [2:0] evec, input logic eis, input logic [7:1] ep);
        checkVal({tag, " int_valid"},  {7'b0, av},   {7'b0, ev});
        checkVal({tag, " int_vec"},    {5'b0, avec}, {5'b0, evec});
        checkVal({tag, " in_service"}, {7'b0, ais},  {7'b0, eis});
        checkVal({tag, " pending"},    {1'b0, apend}, {1'b0, ep});
    endtask

    initial begin
        reset = 1'b1; irq = '0; mask = '0; ack = 1'b0; eoi = 1'b0;

        //     rst irq         mask        ack eoi   valid vec  insvc pending
        addVec(1, 7'b0000000, 7'b0000000, 0, 0,    0, 3'd0, 0, 7'b0000000);
        addVec(0, 7'b0000100, 7'b0000000, 0, 0,    0, 3'd0, 0, 7'b0000100);
        addVec(0, 7'b0000000, 7'b0000000, 0, 0,    1, 3'd3, 0, 7'b0000100);
        addVec(0, 7'b0000000, 7'b0000000, 0, 0,    1, 3'd3, 0, 7'b0000100);
        addVec(0, 7'b0000000, 7'b0000000, 1, 0,    0, 3'd3, 1, 7'b0000000);
        addVec(0, 7'b0000000, 7'b0000000, 1, 0,    0, 3'd3, 1, 7'b0000000);
        addVec(0, 7'b0000000, 7'b0000000, 0, 1,    0, 3'd0, 0, 7'b0000000);
        addVec(0, 7'b0000000, 7'b0000000, 0, 1,    0, 3'd0, 0, 7'b0000000);
        addVec(0, 7'b0100010, 7'b0000000, 0, 0,    0, 3'd0, 0, 7'b0100010);
        addVec(0, 7'b0100010, 7'b0000000, 0, 0,    1, 3'd6, 0, 7'b0100010);
        addVec(0, 7'b0100010, 7'b0000000, 1, 0,    0, 3'd6, 1, 7'b0000010);
        addVec(0, 7'b0100010, 7'b0000000, 0, 1,    0, 3'd0, 0, 7'b0000010);
        addVec(0, 7'b0100010, 7'b0000000, 0, 0,    1, 3'd2, 0, 7'b0000010);
        addVec(0, 7'b0100010, 7'b0000000, 1, 1,    0, 3'd2, 1, 7'b0000000);
        addVec(0, 7'b0000000, 7'b0000000, 0, 1,    0, 3'd0, 0, 7'b0000000);
        addVec(0, 7'b1010000, 7'b1000000, 0, 0,    0, 3'd0, 0, 7'b1010000);
        addVec(0, 7'b1010000, 7'b1000000, 0, 0,    1, 3'd5, 0, 7'b1010000);
        addVec(0, 7'b1010000, 7'b1000000, 1, 0,    0, 3'd5, 1, 7'b1000000);
        addVec(0, 7'b1010000, 7'b1000000, 0, 1,    0, 3'd0, 0, 7'b1000000);
        addVec(0, 7'b1010000, 7'b1000000, 0, 0,    0, 3'd0, 0, 7'b1000000);
        addVec(0, 7'b1010000, 7'b0000000, 0, 0,    1, 3'd7, 0, 7'b1000000);
        addVec(0, 7'b1010000, 7'b0000000, 1, 0,    0, 3'd7, 1, 7'b0000000);
        addVec(0, 7'b0000000, 7'b0000000, 0, 1,    0, 3'd0, 0, 7'b0000000);
        addVec(0, 7'b0001000, 7'b0000000, 0, 0,    0, 3'd0, 0, 7'b0001000);
        addVec(0, 7'b0000000, 7'b0000000, 0, 0,    1, 3'd4, 0, 7'b0001000);
        addVec(0, 7'b1000000, 7'b0000000, 0, 0,    1, 3'd4, 0, 7'b1001000);
        addVec(0, 7'b0000000, 7'b0001000, 0, 0,    1, 3'd4, 0, 7'b1001000);
        addVec(0, 7'b0000000, 7'b0001000, 1, 0,    0, 3'd4, 1, 7'b1000000);
        addVec(0, 7'b0000000, 7'b0000000, 0, 1,    0, 3'd0, 0, 7'b1000000);
        addVec(0, 7'b0000000, 7'b0000000, 0, 0,    1, 3'd7, 0, 7'b1000000);
        addVec(0, 7'b0000000, 7'b0000000, 1, 0,    0, 3'd7, 1, 7'b0000000);
        addVec(0, 7'b0010000, 7'b0000000, 0, 0,    0, 3'd7, 1, 7'b0010000);
        addVec(1, 7'b0000000, 7'b0000000, 0, 0,    0, 3'd0, 0, 7'b0000000);
        addVec(0, 7'b0000000, 7'b0000000, 0, 0,    0, 3'd0, 0, 7'b0000000);
        addVec(0, 7'b0000001, 7'b0000000, 0, 0,    0, 3'd0, 0, 7'b0000001);
        addVec(0, 7'b0000000, 7'b0000000, 0, 0,    1, 3'd1, 0, 7'b0000001);
        addVec(0, 7'b0000001, 7'b0000000, 1, 0,    0, 3'd1, 1, 7'b0000001);
        addVec(0, 7'b0000000, 7'b0000000, 0, 1,    0, 3'd0, 0, 7'b0000001);
        addVec(0, 7'b0000000, 7'b0000000, 0, 0,    1, 3'd1, 0, 7'b0000001);
        addVec(0, 7'b0000000, 7'b0000000, 1, 0,    0, 3'd1, 1, 7'b0000000);
        addVec(0, 7'b0000000, 7'b0000000, 0, 1,    0, 3'd0, 0, 7'b0000000);

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].rst, vecs[k].irq, vecs[k].mask, vecs[k].ack, vecs[k].eoi);
            checkOutput($sformatf("row%0d", k), e_valid, e_vec, e_insvc, e_pend,
                        vecs[k].ev, vecs[k].evec, vecs[k].eis, vecs[k].epend);
        end

        // Line held high across reset release registers as an edge on the first cycle out.
        applyStimulus(1, 7'b0000010, 7'b0, 0, 0);
        checkOutput("rstHeld", e_valid, e_vec, e_insvc, e_pend, 0, 3'd0, 0, 7'b0000000);
        applyStimulus(0, 7'b0000010, 7'b0, 0, 0);
        checkOutput("relEdge", e_valid, e_vec, e_insvc, e_pend, 0, 3'd0, 0, 7'b0000010);
        applyStimulus(0, 7'b0000010, 7'b0, 0, 0);
        checkOutput("relReq", e_valid, e_vec, e_insvc, e_pend, 1, 3'd2, 0, 7'b0000010);
        applyStimulus(0, 7'b0000010, 7'b0, 1, 0);
        checkOutput("relAck", e_valid, e_vec, e_insvc, e_pend, 0, 3'd2, 1, 7'b0000000);
        applyStimulus(0, 7'b0000000, 7'b0, 0, 1);
        checkOutput("relEoi", e_valid, e_vec, e_insvc, e_pend, 0, 3'd0, 0, 7'b0000000);

        // Level mode with line 1 held: re-requested one cycle after every eoi.
        applyStimulus(1, 7'b0000001, 7'b0, 0, 0);
        checkOutput("lvlRst", l_valid, l_vec, l_insvc, l_pend, 0, 3'd0, 0, 7'b0000000);
        applyStimulus(0, 7'b0000001, 7'b0, 0, 0);
        checkOutput("lvlSet", l_valid, l_vec, l_insvc, l_pend, 0, 3'd0, 0, 7'b0000001);
        applyStimulus(0, 7'b0000001, 7'b0, 0, 0);
        checkOutput("lvlReq", l_valid, l_vec, l_insvc, l_pend, 1, 3'd1, 0, 7'b0000001);
        for (int n = 0; n < 2; n++) begin
            applyStimulus(0, 7'b0000001, 7'b0, 1, 0);
            checkOutput($sformatf("lvlAck%0d", n), l_valid, l_vec, l_insvc, l_pend,
                        0, 3'd1, 1, 7'b0000001);
            applyStimulus(0, 7'b0000001, 7'b0, 0, 1);
            checkOutput($sformatf("lvlEoi%0d", n), l_valid, l_vec, l_insvc, l_pend,
                        0, 3'd0, 0, 7'b0000001);
            applyStimulus(0, 7'b0000001, 7'b0, 0, 0);
            checkOutput($sformatf("lvlReReq%0d", n), l_valid, l_vec, l_insvc, l_pend,
                        1, 3'd1, 0, 7'b0000001);
            checkOutput($sformatf("edgeNoReReq%0d", n), e_valid, e_vec, e_insvc, e_pend,
                        0, 3'd0, 0, 7'b0000000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
